// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator and its per-voice counters.
package voice_allocator_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [DUR_W-1:0] dur_t;
endpackage

// File: rtl/voice_allocator_voice_counter.sv
// Per-voice remaining-beat down-counter; a load overrides a same-cycle decrement.
module voice_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         busy
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);
endmodule

// File: rtl/voice_allocator.sv
// Round-robin allocator spreading a single note stream over NUM_VOICES players.
// Define VOICE_STEAL_EN to let a note steal the voice closest to finishing when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W = 6
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          play,
  input  logic                                          beat,
  input  logic                                          new_note,
  input  logic [voice_allocator_pkg::NOTE_W-1:0]        note,
  input  logic [DUR_W-1:0]                              duration,
  output logic                                          player_ready,
  output logic [NUM_VOICES-1:0]                         load_note,
  output logic [voice_allocator_pkg::NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]                         voice_active
);
  import voice_allocator_pkg::*;

  localparam int PW = $clog2(NUM_VOICES);

  logic [DUR_W-1:0]      count [NUM_VOICES];
  note_t                 notes [NUM_VOICES];
  logic [NUM_VOICES-1:0] free;
  logic [NUM_VOICES-1:0] load_vec;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         target;
  logic [PW-1:0]         target_q;
  logic                  accept_q;
  logic                  any_free;
  logic                  accept;
  logic                  do_load;
  logic                  dec;

  assign any_free = |free;
  assign dec      = beat & play;

`ifdef VOICE_STEAL_EN
  assign player_ready = play & ~reset;
`else
  assign player_ready = play & any_free & ~reset;
`endif

  assign accept  = new_note & player_ready;
  // Rests and zero-length notes are consumed without touching any voice.
  assign do_load = accept && (note != NOTE_REST) && (duration != '0);

  always_comb begin
    int j;
    logic found;
    target = rr_ptr;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      j = (int'(rr_ptr) + k) % NUM_VOICES;
      if (!found && free[j]) begin
        target = PW'(j);
        found  = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    if (!any_free) begin
      logic [DUR_W-1:0] min_val;
      min_val = count[0];
      target  = '0;
      for (int k = 1; k < NUM_VOICES; k++) begin
        if (count[k] < min_val) begin
          min_val = count[k];
          target  = PW'(k);
        end
      end
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign load_vec[gi] = do_load && (target == PW'(gi));
      assign load_note[gi] = accept_q && (target_q == PW'(gi));
      assign free[gi] = (count[gi] == '0) && !load_note[gi];
      assign voice_note[gi*NOTE_W +: NOTE_W] = notes[gi];

      voice_counter #(.W(DUR_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_vec[gi]),
        .load_val (duration),
        .dec      (dec),
        .count    (count[gi]),
        .busy     (voice_active[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      accept_q <= 1'b0;
      target_q <= '0;
      for (int k = 0; k < NUM_VOICES; k++) notes[k] <= NOTE_REST;
    end else begin
      accept_q <= do_load;
      target_q <= target;
      if (do_load) begin
        notes[target] <= note;
        rr_ptr <= (target == PW'(NUM_VOICES - 1)) ? '0 : target + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against a beat-count reference model.
module tb_voice_allocator;
  localparam int NV = 3;
  localparam int DW = 6;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          beat;
  logic          new_note;
  logic [5:0]    note;
  logic [DW-1:0] duration;
  logic          player_ready;
  logic [NV-1:0] load_note;
  logic [6*NV-1:0] voice_note;
  logic [NV-1:0] voice_active;

  int n_tests = 0;
  int n_fail = 0;

  // reference model state: remaining beats and last note per voice
  int            m_cnt [NV];
  logic [5:0]    m_note [NV];
  int            m_rr;
  logic [NV-1:0] exp_q [$];

  voice_allocator #(.NUM_VOICES(NV), .DUR_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .beat         (beat),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .player_ready (player_ready),
    .load_note    (load_note),
    .voice_note   (voice_note),
    .voice_active (voice_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic r, input logic p);
    bit any_free;
    any_free = 1'b0;
    for (int i = 0; i < NV; i++) if (m_cnt[i] == 0) any_free = 1'b1;
    return !r && p && (STEAL || any_free);
  endfunction

  function automatic int model_pick();
    int best;
    for (int k = 0; k < NV; k++) begin
      if (m_cnt[(m_rr + k) % NV] == 0) return (m_rr + k) % NV;
    end
    best = 0;
    for (int i = 1; i < NV; i++) if (m_cnt[i] < m_cnt[best]) best = i;
    return best;
  endfunction

  task automatic model_step(input logic r, input logic p, input logic b, input logic nn,
                            input logic [5:0] n, input logic [DW-1:0] d);
    int t;
    logic [NV-1:0] ld;
    t = -1;
    ld = '0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_cnt[i] = 0;
        m_note[i] = 6'd0;
      end
      m_rr = 0;
    end else begin
      if (nn && model_ready(r, p) && n != 6'd0 && d != '0) t = model_pick();
      if (b && p) for (int i = 0; i < NV; i++) if (m_cnt[i] > 0) m_cnt[i]--;
      if (t >= 0) begin
        m_cnt[t] = int'(d);
        m_note[t] = n;
        m_rr = (t + 1) % NV;
        ld[t] = 1'b1;
      end
    end
    exp_q.push_back(ld);
  endtask

  task automatic step(input logic r, input logic p, input logic b, input logic nn,
                      input logic [5:0] n, input logic [DW-1:0] d);
    logic [NV-1:0] act;
    logic [6*NV-1:0] nv;
    logic [NV-1:0] exp_ld;
    reset = r; play = p; beat = b; new_note = nn; note = n; duration = d;
    #1;
    check("player_ready", 32'(player_ready), 32'(model_ready(r, p)));
    model_step(r, p, b, nn, n, d);
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      act[i] = (m_cnt[i] != 0);
      nv[6*i +: 6] = m_note[i];
    end
    exp_ld = exp_q.pop_front();
    check("load_note", 32'(load_note), 32'(exp_ld));
    check("voice_active", 32'(voice_active), 32'(act));
    check("voice_note", 32'(voice_note), 32'(nv));
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; beat = 1'b0; new_note = 1'b0; note = '0; duration = '0;
    for (int i = 0; i < NV; i++) begin
      m_cnt[i] = 0;
      m_note[i] = 6'd0;
    end
    m_rr = 0;
    @(posedge clk);
    #1;

    // reset state, then play
    step(1, 0, 0, 0, 0, 0);
    check("reset_active", 32'(voice_active), 32'd0);
    step(0, 1, 0, 0, 0, 0);
    #1;
    check("ready_after_reset", 32'(player_ready), 32'd1);

    // three consecutive notes fill all voices round-robin
    step(0, 1, 0, 1, 6'd10, 6'd4);
    check("load_v0", 32'(load_note), 32'b001);
    step(0, 1, 0, 1, 6'd12, 6'd2);
    check("load_v1", 32'(load_note), 32'b010);
    step(0, 1, 0, 1, 6'd15, 6'd3);
    check("load_v2", 32'(load_note), 32'b100);
    check("three_notes", 32'(voice_note), 32'({6'd15, 6'd12, 6'd10}));
`ifndef VOICE_STEAL_EN
    #1;
    check("ready_all_busy", 32'(player_ready), 32'd0);
`endif
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("v1_freed", 32'(voice_active), 32'b101);
    #1;
    check("ready_after_free", 32'(player_ready), 32'd1);

    // reset with voices busy aborts everything and rewinds rr_ptr
    step(1, 1, 0, 0, 0, 0);
    check("reset_abort", 32'(voice_active), 32'd0);
    step(0, 1, 0, 1, 6'd33, 6'd2);
    check("rr_after_reset", 32'(load_note), 32'b001);

    // voice0 busy, rr at 1: next note goes to voice1, the one after to voice2
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 6'd10, 6'd9);
    step(0, 1, 0, 1, 6'd7, 6'd3);
    check("rr_voice1", 32'(load_note), 32'b010);
    step(0, 1, 0, 1, 6'd8, 6'd2);
    check("rr_voice2", 32'(load_note), 32'b100);

    // rests and zero durations consume nothing
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 6'd11, 6'd6);
    step(0, 1, 0, 1, 6'd0, 6'd5);
    check("rest_no_load", 32'(load_note), 32'd0);
    step(0, 1, 0, 1, 6'd9, 6'd0);
    check("zero_dur_no_load", 32'(load_note), 32'd0);
    step(0, 1, 0, 1, 6'd5, 6'd1);
    check("rr_kept", 32'(load_note), 32'b010);

    // paused beats freeze counters
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    check("paused_active", 32'(voice_active), 32'b011);

    // load and beat in the same cycle: full duration retained
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 6'd3, 6'd3);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("load_beat_live", 32'(voice_active), 32'b001);
    step(0, 1, 1, 0, 0, 0);
    check("load_beat_done", 32'(voice_active), 32'b000);

    // all busy with counts 5,2,2 then note 20 dur 4
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 6'd1, 6'd5);
    step(0, 1, 0, 1, 6'd2, 6'd2);
    step(0, 1, 0, 1, 6'd3, 6'd2);
`ifdef VOICE_STEAL_EN
    step(0, 1, 0, 1, 6'd20, 6'd4);
    check("steal_v1", 32'(load_note), 32'b010);
    check("steal_note", 32'(voice_note[11:6]), 32'd20);
`else
    #1;
    check("no_steal_ready", 32'(player_ready), 32'd0);
`endif

    // random traffic from a well-behaved song reader
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic r, p, b, nn;
      logic [5:0] n;
      logic [DW-1:0] d;
      r = ($urandom_range(0, 79) == 0);
      p = ($urandom_range(0, 7) != 0);
      b = ($urandom_range(0, 2) == 0);
      n = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      d = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 12));
      nn = model_ready(r, p) && ($urandom_range(0, 1) == 1);
      step(r, p, b, nn, n, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
